// File: rtl/mem_pkg.sv
// Shared encodings and constants for the memory-side SRAM responder and its helpers.
package mem_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_ACC = 3'd1;
    localparam logic [2:0] S_WR_ACC = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_CAP    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        RD_ACC = S_RD_ACC,
        WR_ACC = S_WR_ACC,
        WAIT   = S_WAIT,
        CAP    = S_CAP,
        DONE   = S_DONE
    } mem_state_t;

    localparam logic [3:0]  BYTEEN_FULL = 4'b1111;
    localparam logic [31:0] OOR_RDATA   = 32'hDEADBEEF;
    localparam int          WAITCNT_W   = 4;

endpackage

// File: rtl/mem_bytemerge.sv
// Byte-lane merge: lanes with byteen set take new_word, the rest keep old_word.
module mem_bytemerge
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-bus responder for a word-wide SRAM without byte enables; partial writes use read-modify-write.
// Optional macro MEM_RESP_BOUNDS_EN: requests with memadr above the SRAM depth complete at once (reads return OOR_RDATA).
//
// state  | meaning
// IDLE   | waiting for memen, latches the request
// RD_ACC | SRAM read strobe
// WR_ACC | SRAM write strobe with the write-data register
// WAIT   | SRAM access wait cycles
// CAP    | SRAM read data valid: capture for read, merge for RMW
// DONE   | memdone pulse, bus drive on reads
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADR_W       = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic [26:0]      memadr,
    input  logic [31:0]      memwdata,
    output logic [31:0]      memrdata,
    output logic             memdataoe,
    input  logic [3:0]       membyteen,
    input  logic             memrwb,
    input  logic             memen,
    output logic             memdone,
    output logic [ADR_W-1:0] sramadr,
    output logic [31:0]      sramwdata,
    output logic             sramce,
    output logic             sramwe,
    input  logic [31:0]      sramrdata
);

    localparam logic [WAITCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAITCNT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t           state, state_nx;
    logic [WAITCNT_W-1:0] wait_cnt;
    logic [31:0]          wdata_q;
    logic [31:0]          merged;
    logic [3:0]           byteen_q;
    logic                 rwb_q;
    logic                 rmw_q;
    logic                 acc_wr;
    logic                 oor;
    logic                 wait_done;

`ifdef MEM_RESP_BOUNDS_EN
    assign oor = |memadr[26:ADR_W];
`else
    logic unused_upper;
    assign oor          = 1'b0;
    assign unused_upper = ^memadr[26:ADR_W];
`endif

    assign wait_done = (wait_cnt == '0);
    assign sramwdata = wdata_q;

    mem_bytemerge u_merge (
        .old_word (sramrdata),
        .new_word (wdata_q),
        .byteen   (byteen_q),
        .merged   (merged)
    );

    always_ff @(posedge ph1) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
            rwb_q    <= 1'b0;
            rmw_q    <= 1'b0;
            acc_wr   <= 1'b0;
            sramadr  <= '0;
            memrdata <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (memen) begin
                        sramadr  <= memadr[ADR_W-1:0];
                        wdata_q  <= memwdata;
                        byteen_q <= membyteen;
                        rwb_q    <= memrwb;
                        rmw_q    <= !memrwb && !oor && (membyteen != BYTEEN_FULL)
                                    && (membyteen != 4'b0000);
                        if (oor && memrwb) memrdata <= OOR_RDATA;
                    end
                end
                RD_ACC: begin
                    wait_cnt <= WAIT_LOAD;
                    acc_wr   <= 1'b0;
                end
                WR_ACC: begin
                    wait_cnt <= WAIT_LOAD;
                    acc_wr   <= 1'b1;
                end
                WAIT: begin
                    if (!wait_done) wait_cnt <= wait_cnt - WAITCNT_W'(1);
                end
                CAP: begin
                    // RMW reuses the write-data register as the merged word for WR_ACC
                    if (rmw_q) wdata_q  <= merged;
                    else       memrdata <= sramrdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        memdone   = 1'b0;
        memdataoe = 1'b0;
        sramce    = 1'b0;
        sramwe    = 1'b0;
        case (state)
            IDLE: begin
                if (memen) begin
                    if (oor)                             state_nx = DONE;
                    else if (memrwb)                     state_nx = RD_ACC;
                    else if (membyteen == BYTEEN_FULL)   state_nx = WR_ACC;
                    else if (membyteen == 4'b0000)       state_nx = DONE;
                    else                                 state_nx = RD_ACC;
                end
            end
            RD_ACC: begin
                sramce   = 1'b1;
                state_nx = (WAIT_CYCLES > 0) ? WAIT : CAP;
            end
            WR_ACC: begin
                sramce   = 1'b1;
                sramwe   = 1'b1;
                state_nx = (WAIT_CYCLES > 0) ? WAIT : DONE;
            end
            WAIT: begin
                if (wait_done) state_nx = acc_wr ? DONE : CAP;
            end
            CAP: begin
                state_nx = rmw_q ? WR_ACC : DONE;
            end
            DONE: begin
                memdone   = 1'b1;
                memdataoe = rwb_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: behavioural SRAM plus a word-level reference model.
module tb_mem_responder;

    localparam int AW = 12;
    localparam int W  = 1;

    logic          ph1;
    logic          reset;
    logic [26:0]   memadr;
    logic [31:0]   memwdata;
    logic [31:0]   memrdata;
    logic          memdataoe;
    logic [3:0]    membyteen;
    logic          memrwb;
    logic          memen;
    logic          memdone;
    logic [AW-1:0] sramadr;
    logic [31:0]   sramwdata;
    logic          sramce;
    logic          sramwe;
    logic [31:0]   sramrdata;

    int vectors;
    int miscompares;

    logic [31:0] sram    [0:(1<<AW)-1];
    logic [31:0] rd_pipe [0:W];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [31:0] exp_rdata;

    mem_responder #(.ADR_W(AW), .WAIT_CYCLES(W)) dut (
        .ph1       (ph1),
        .reset     (reset),
        .memadr    (memadr),
        .memwdata  (memwdata),
        .memrdata  (memrdata),
        .memdataoe (memdataoe),
        .membyteen (membyteen),
        .memrwb    (memrwb),
        .memen     (memen),
        .memdone   (memdone),
        .sramadr   (sramadr),
        .sramwdata (sramwdata),
        .sramce    (sramce),
        .sramwe    (sramwe),
        .sramrdata (sramrdata)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // SRAM: read data appears W+1 cycles after the strobe cycle
    always @(posedge ph1) begin
        if (sramce && !sramwe) rd_pipe[0] <= sram[sramadr];
        for (int i = 1; i <= W; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (sramce && sramwe) sram[sramadr] <= sramwdata;
    end
    assign sramrdata = rd_pipe[W];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_oor(input logic [26:0] adr);
`ifdef MEM_RESP_BOUNDS_EN
        return |adr[26:AW];
`else
        return (adr[0] & 1'b0);
`endif
    endfunction

    task automatic txn(input logic [26:0] adr, input logic [31:0] wd, input logic [3:0] be,
                       input logic rwb, input bit keep);
        logic [AW-1:0] low;
        logic [31:0]   mask;
        logic [31:0]   exp_sw;
        logic          oor;
        int            lat;
        int            exp_ce;
        int            exp_we;
        int            ce;
        int            we;
        int            cyc;
        bit            done;
        low    = adr[AW-1:0];
        oor    = is_oor(adr);
        mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        exp_sw = (wd & mask) | (ref_mem[low] & ~mask);
        if (oor || (!rwb && be == 4'h0)) begin
            lat = 1;         exp_ce = 0; exp_we = 0;
        end else if (rwb) begin
            lat = 3 + W;     exp_ce = 1; exp_we = 0;
        end else if (be == 4'hF) begin
            lat = 2 + W;     exp_ce = 1; exp_we = 1;
        end else begin
            lat = 4 + 2 * W; exp_ce = 2; exp_we = 1;
        end
        memadr    = adr;
        memwdata  = wd;
        membyteen = be;
        memrwb    = rwb;
        memen     = 1'b1;
        ce = 0; we = 0; cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            @(posedge ph1); #1;
            cyc++;
            if (sramce) begin
                ce++;
                chk("sramadr", 32'(sramadr), 32'(low));
                if (sramwe) begin
                    we++;
                    chk("sramwdata", sramwdata, exp_sw);
                end
            end
            if (memdone) done = 1;
        end
        chk("latency", 32'(cyc), 32'(lat));
        chk("ce_count", 32'(ce), 32'(exp_ce));
        chk("we_count", 32'(we), 32'(exp_we));
        if (oor) begin
            if (rwb) exp_rdata = 32'hDEADBEEF;
        end else if (rwb) begin
            exp_rdata = ref_mem[low];
        end else if (be != 4'h0) begin
            ref_mem[low] = exp_sw;
        end
        chk("memrdata", memrdata, exp_rdata);
        chk("memdataoe", 32'(memdataoe), 32'(rwb));
        if (!keep) memen = 1'b0;
        @(posedge ph1); #1;
        chk("idle_gap", {30'd0, memdone, memdataoe}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_rdata   = 32'd0;
        reset       = 1'b1;
        memen       = 1'b0;
        memadr      = '0;
        memwdata    = '0;
        membyteen   = '0;
        memrwb      = 1'b1;
        for (int i = 0; i <= W; i++) rd_pipe[i] = '0;
        repeat (3) @(posedge ph1);
        #1;
        chk("rst_outs", {28'd0, memdone, memdataoe, sramce, sramwe}, 32'd0);
        chk("rst_rdata", memrdata, 32'd0);
        chk("rst_sadr", 32'(sramadr), 32'd0);
        chk("rst_swdata", sramwdata, 32'd0);
        reset = 1'b0;
        @(posedge ph1); #1;

        for (int a = 0; a < 17; a++) txn(27'(a), $urandom, 4'hF, 1'b0, 0);
        txn(27'h10, 32'hAABBCCDD, 4'hF, 1'b0, 0);

        txn(27'hABC, 32'h12345678, 4'hF, 1'b0, 0);
        txn(27'hABC, 32'h0, 4'h0, 1'b1, 0);
        chk("rd_abc", memrdata, 32'h12345678);

        txn(27'h10, 32'h11223344, 4'b0101, 1'b0, 0);
        txn(27'h10, 32'h0, 4'h0, 1'b1, 0);
        chk("rmw_word", memrdata, 32'hAA22CC44);

        txn(27'h3, 32'hFFFFFFFF, 4'h0, 1'b0, 0);

        for (int a = 0; a < 4; a++) txn(27'(a), 32'h0, 4'h0, 1'b1, a != 3);

        // reset in the WAIT state of a partial write
        memadr = 27'h5; memwdata = 32'hCAFEF00D; membyteen = 4'b0011; memrwb = 1'b0; memen = 1'b1;
        @(posedge ph1); #1;
        @(posedge ph1); #1;
        reset = 1'b1;
        @(posedge ph1); #1;
        reset = 1'b0;
        memen = 1'b0;
        exp_rdata = 32'd0;
        chk("abort_outs", {28'd0, memdone, memdataoe, sramce, sramwe}, 32'd0);
        chk("abort_rdata", memrdata, 32'd0);
        chk("abort_sadr", 32'(sramadr), 32'd0);
        chk("abort_swdata", sramwdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge ph1); #1;
            chk("abort_quiet", {30'd0, memdone, sramce}, 32'd0);
        end
        txn(27'h5, 32'h0, 4'h0, 1'b1, 0);

        txn(27'h1000, 32'h0, 4'h0, 1'b1, 0);

        for (int n = 0; n < 60; n++) begin
            logic [26:0] adr;
            logic [3:0]  be;
            int          sel;
            adr = 27'($urandom_range(0, 16));
            if ($urandom_range(0, 7) == 0) adr[26:AW] = 15'($urandom_range(1, 32767));
            sel = $urandom_range(0, 5);
            be  = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom);
            txn(adr, $urandom, be, 1'($urandom), $urandom_range(0, 1) == 1);
        end
        memen = 1'b0;
        @(posedge ph1); #1;
        for (int a = 0; a < 17; a++) txn(27'(a), 32'h0, 4'h0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
